// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
`timescale 1ns / 1ps
//==============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared FSM state type and requester IDs for the RAM arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
`timescale 1ns / 1ps
//==============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester (IF/DM) and single-port RAM signal bundle.
// Revision : 1.0 - initial release
//==============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              en_ram_in;
    logic              we_ram_in;
    logic [ADDR_W-1:0] addr_ram_in;
    logic [DATA_W-1:0] din_ram_in;
    logic [DATA_W-1:0] dout_ram_out;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dout_ram_out,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output en_ram_in, we_ram_in, addr_ram_in, din_ram_in
    );

    // Requester / RAM side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dout_ram_out,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  en_ram_in, we_ram_in, addr_ram_in, din_ram_in
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
`default_nettype none
`timescale 1ns / 1ps
//==============================================================================
// Module   : mem_arbiter_pick
// Brief    : Grant decision. MEM_ARBITER_ROUND_ROBIN_EN selects alternating
//            grant on contention; otherwise DM has fixed priority.
// Revision : 1.0 - initial release
//==============================================================================
module mem_arbiter_pick (
    input  logic if_req,
    input  logic dm_req,
    input  logic last_grant,
    output logic winner
);
    import mem_arbiter_pkg::*;

    // With no request pending the result is unused; it simply follows the pointer.
    always_comb begin
        winner = last_grant;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (if_req && dm_req) begin
            winner = ~last_grant;
        end else if (dm_req) begin
            winner = REQ_DM;
        end else if (if_req) begin
            winner = REQ_IF;
        end
`else
        if (dm_req) begin
            winner = REQ_DM;
        end else if (if_req) begin
            winner = REQ_IF;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
//==============================================================================
// Module   : mem_arbiter
// Brief    : IF/DM arbiter for a 1-cycle-latency single-port synchronous RAM.
//            Optional macro: MEM_ARBITER_ROUND_ROBIN_EN (round-robin grant).
// Revision : 1.0 - initial release
//==============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic             busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                w_any_req;
    logic                w_winner;
    logic                w_last_grant;
    logic                w_grant;
    logic                w_rd_resp;

    assign w_any_req = bus.if_req | bus.dm_req;
    assign w_grant   = (r_state == IDLE) && w_any_req;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic r_last_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= REQ_DM;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = REQ_DM;
`endif

    mem_arbiter_pick u_pick (
        .if_req     (bus.if_req),
        .dm_req     (bus.dm_req),
        .last_grant (w_last_grant),
        .winner     (w_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.en_ram_in = 1'b0;
        bus.we_ram_in = 1'b0;
        bus.if_ack    = 1'b0;
        bus.dm_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt   = RESP;
                bus.en_ram_in = 1'b1;
                bus.we_ram_in = r_we;
            end
            RESP: begin
                w_state_nxt = IDLE;
                bus.if_ack  = (r_owner == REQ_IF);
                bus.dm_ack  = (r_owner == REQ_DM);
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // IF grants never write; the DM write data is only captured on a DM grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= REQ_DM;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_winner;
            if (w_winner == REQ_DM) begin
                r_we    <= bus.dm_we;
                r_addr  <= bus.dm_addr;
                r_wdata <= bus.dm_wdata;
            end else begin
                r_we    <= 1'b0;
                r_addr  <= bus.if_addr;
            end
        end
    end

    assign bus.addr_ram_in = r_addr;
    assign bus.din_ram_in  = r_wdata;

    // RAM data is only valid during RESP, so the ack cycle passes it straight
    // through and the holding register takes over from the next cycle on.
    assign w_rd_resp = (r_state == RESP) && !r_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_rd_resp) begin
            if (r_owner == REQ_IF) begin
                r_if_rdata <= bus.dout_ram_out;
            end else begin
                r_dm_rdata <= bus.dout_ram_out;
            end
        end
    end

    assign bus.if_rdata = (w_rd_resp && (r_owner == REQ_IF)) ? bus.dout_ram_out : r_if_rdata;
    assign bus.dm_rdata = (w_rd_resp && (r_owner == REQ_DM)) ? bus.dout_ram_out : r_dm_rdata;

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
//==============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a RAM model and a
//            transaction-timing reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, one cycle read latency
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (bus.en_ram_in) begin
            if (bus.we_ram_in) ram[bus.addr_ram_in] <= bus.din_ram_in;
            bus.dout_ram_out <= ram[bus.addr_ram_in];
        end
    end

    // Reference model: a grant may happen 3 edges after the previous one;
    // the RAM is touched one edge after grant and the ack is in that cycle.
    logic [DW-1:0] ref_mem [256];
    int            cyc;
    int            m_gt;
    logic          m_owner, m_we, m_last, ref_win;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;

    function automatic logic ref_winner(input logic ifr, input logic dmr, input logic last);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (ifr && dmr) return (last == REQ_DM) ? REQ_IF : REQ_DM;
`else
        if (dmr) return REQ_DM;
`endif
        return ifr ? REQ_IF : REQ_DM;
    endfunction

    assign ref_win = ref_winner(bus.if_req, bus.dm_req, m_last);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc        <= 0;
            m_gt       <= -100;
            m_last     <= REQ_DM;
            m_if_rdata <= '0;
            m_dm_rdata <= '0;
        end else begin
            cyc <= cyc + 1;
            if ((cyc + 1 >= m_gt + 3) && (bus.if_req || bus.dm_req)) begin
                m_gt    <= cyc + 1;
                m_owner <= ref_win;
                m_last  <= ref_win;
                m_addr  <= (ref_win == REQ_DM) ? bus.dm_addr : bus.if_addr;
                m_we    <= (ref_win == REQ_DM) && bus.dm_we;
                m_wdata <= bus.dm_wdata;
            end
            if (cyc + 1 == m_gt + 1) begin
                if (m_we) ref_mem[m_addr] <= m_wdata;
                else if (m_owner == REQ_IF) m_if_rdata <= ref_mem[m_addr];
                else m_dm_rdata <= ref_mem[m_addr];
            end
        end
    end

    logic exp_en, exp_if_ack, exp_dm_ack, exp_busy;
    assign exp_en     = (cyc == m_gt);
    assign exp_if_ack = (cyc == m_gt + 1) && (m_owner == REQ_IF);
    assign exp_dm_ack = (cyc == m_gt + 1) && (m_owner == REQ_DM);
    assign exp_busy   = (cyc == m_gt) || (cyc == m_gt + 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    task automatic settle();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (bus.en_ram_in !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %b want 0", bus.en_ram_in); end
        n_cmp++; if (bus.we_ram_in !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus.we_ram_in); end
        n_cmp++; if (bus.addr_ram_in !== 8'h00) begin n_bad++; $display("FAIL rst_addr: got %h want 00", bus.addr_ram_in); end
        n_cmp++; if (bus.din_ram_in !== 16'h0000) begin n_bad++; $display("FAIL rst_din: got %h want 0000", bus.din_ram_in); end
        n_cmp++; if ({bus.if_ack, bus.dm_ack} !== 2'b00) begin n_bad++; $display("FAIL rst_ack: got %b want 00", {bus.if_ack, bus.dm_ack}); end
        n_cmp++; if (bus.if_rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_if_rdata: got %h want 0000", bus.if_rdata); end
        n_cmp++; if (bus.dm_rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_dm_rdata: got %h want 0000", bus.dm_rdata); end
        bus.if_req = 1'b1;
        tick();
        n_cmp++; if ({busy, bus.en_ram_in} !== 2'b00) begin n_bad++; $display("FAIL rst_held: busy/en got %b want 00", {busy, bus.en_ram_in}); end
        bus.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        settle();
        ram[8'h10]     <= 16'hABCD;
        ref_mem[8'h10] <= 16'hABCD;
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h10;
        tick();
        n_cmp++; if (bus.en_ram_in !== 1'b1) begin n_bad++; $display("FAIL ifrd_en: got %b want 1", bus.en_ram_in); end
        n_cmp++; if (bus.we_ram_in !== 1'b0) begin n_bad++; $display("FAIL ifrd_we: got %b want 0", bus.we_ram_in); end
        n_cmp++; if (bus.addr_ram_in !== 8'h10) begin n_bad++; $display("FAIL ifrd_addr: got %h want 10", bus.addr_ram_in); end
        n_cmp++; if (bus.if_ack !== 1'b0) begin n_bad++; $display("FAIL ifrd_early_ack: got %b want 0", bus.if_ack); end
        tick();
        n_cmp++; if (bus.if_ack !== 1'b1) begin n_bad++; $display("FAIL ifrd_ack: got %b want 1", bus.if_ack); end
        n_cmp++; if (bus.if_rdata !== 16'hABCD) begin n_bad++; $display("FAIL ifrd_data: got %h want abcd", bus.if_rdata); end
        n_cmp++; if ({bus.dm_ack, bus.en_ram_in} !== 2'b00) begin n_bad++; $display("FAIL ifrd_resp_misc: dm_ack/en got %b want 00", {bus.dm_ack, bus.en_ram_in}); end
        bus.if_req = 1'b0;
        tick();
        n_cmp++; if ({bus.if_ack, busy} !== 2'b00) begin n_bad++; $display("FAIL ifrd_after: ack/busy got %b want 00", {bus.if_ack, busy}); end
        n_cmp++; if (bus.if_rdata !== 16'hABCD) begin n_bad++; $display("FAIL ifrd_hold: got %h want abcd", bus.if_rdata); end
        n_cmp++; if (bus.addr_ram_in !== 8'h10) begin n_bad++; $display("FAIL ifrd_addr_hold: got %h want 10", bus.addr_ram_in); end
    endtask

    task automatic test_dm_write_read();
        int k;
        settle();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 8'h20; bus.dm_wdata = 16'h1234;
        k = 0;
        do begin tick(); k++; end while (!bus.dm_ack && k < 10);
        n_cmp++; if (bus.dm_ack !== 1'b1) begin n_bad++; $display("FAIL dmwr_ack: got %b want 1 within 10 cycles", bus.dm_ack); end
        n_cmp++; if (ram[8'h20] !== 16'h1234) begin n_bad++; $display("FAIL dmwr_ram: got %h want 1234", ram[8'h20]); end
        n_cmp++; if (bus.dm_rdata !== m_dm_rdata) begin n_bad++; $display("FAIL dmwr_rdata_kept: got %h want %h", bus.dm_rdata, m_dm_rdata); end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        repeat (2) tick();
        bus.dm_req = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!bus.dm_ack && k < 10);
        n_cmp++; if (bus.dm_ack !== 1'b1) begin n_bad++; $display("FAIL dmrd_ack: got %b want 1 within 10 cycles", bus.dm_ack); end
        n_cmp++; if (bus.dm_rdata !== 16'h1234) begin n_bad++; $display("FAIL dmrd_data: got %h want 1234", bus.dm_rdata); end
        bus.dm_req = 1'b0;
        tick();
        n_cmp++; if (bus.dm_rdata !== 16'h1234) begin n_bad++; $display("FAIL dmrd_hold: got %h want 1234", bus.dm_rdata); end
    endtask

    task automatic test_contention();
        logic exp_order [4];
        logic got [4];
        int   ng, both;
        settle();
        apply_reset();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_order[0] = REQ_IF; exp_order[1] = REQ_DM; exp_order[2] = REQ_IF; exp_order[3] = REQ_DM;
`else
        exp_order[0] = REQ_DM; exp_order[1] = REQ_DM; exp_order[2] = REQ_DM; exp_order[3] = REQ_DM;
`endif
        ng = 0; both = 0;
        bus.if_req = 1'b1; bus.if_addr = 8'h30;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 8'h40;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (bus.if_ack && bus.dm_ack) both++;
            if (bus.if_ack) begin got[ng] = REQ_IF; ng++; end
            else if (bus.dm_ack) begin got[ng] = REQ_DM; ng++; end
        end
        idle_inputs();
        n_cmp++; if (ng != 4) begin n_bad++; $display("FAIL cont_count: got %0d acks want 4 within 40 cycles", ng); end
        n_cmp++; if (both != 0) begin n_bad++; $display("FAIL cont_dual_ack: got %0d cycles with both acks want 0", both); end
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                n_cmp++;
                if (got[i] !== exp_order[i]) begin n_bad++; $display("FAIL cont_order[%0d]: got %b want %b (0=IF 1=DM)", i, got[i], exp_order[i]); end
            end
        end
    endtask

    task automatic test_drop_after_accept();
        int n_en, n_ack;
        settle();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 8'($urandom_range(255, 0));
        tick();
        bus.dm_req = 1'b0;
        n_en = 0; n_ack = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.en_ram_in) n_en++;
            if (bus.dm_ack) n_ack++;
            tick();
        end
        n_cmp++; if (n_ack != 1) begin n_bad++; $display("FAIL drop_ack: got %0d dm_ack pulses want 1", n_ack); end
        n_cmp++; if (n_en != 1) begin n_bad++; $display("FAIL drop_access: got %0d accesses want 1", n_en); end
    endtask

    task automatic test_reset_abort();
        settle();
        bus.if_req = 1'b1; bus.if_addr = 8'h55;
        tick();
        n_cmp++; if (bus.en_ram_in !== 1'b1) begin n_bad++; $display("FAIL abort_pre_en: got %b want 1", bus.en_ram_in); end
        bus.if_req = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({busy, bus.en_ram_in} !== 2'b00) begin n_bad++; $display("FAIL abort_in_rst: busy/en got %b want 00", {busy, bus.en_ram_in}); end
        n_cmp++; if (bus.if_rdata !== 16'h0000) begin n_bad++; $display("FAIL abort_rdata_clr: got %h want 0000", bus.if_rdata); end
        #2 rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if ({busy, bus.en_ram_in, bus.if_ack, bus.dm_ack} !== 4'b0000) begin
                n_bad++;
                $display("FAIL abort_cycle%0d: busy/en/if_ack/dm_ack got %b want 0000", c, {busy, bus.en_ram_in, bus.if_ack, bus.dm_ack});
            end
        end
    endtask

    task automatic test_throughput();
        int n_ack, n_consec;
        logic prev_en;
        settle();
        n_ack = 0; n_consec = 0; prev_en = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 8'($urandom_range(255, 0));
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.en_ram_in && prev_en) n_consec++;
            prev_en = bus.en_ram_in;
            if (bus.if_ack) n_ack++;
        end
        bus.if_req = 1'b0;
        n_cmp++; if (n_ack != 10) begin n_bad++; $display("FAIL tput_acks: got %0d want 10", n_ack); end
        n_cmp++; if (n_consec != 0) begin n_bad++; $display("FAIL tput_back2back_en: got %0d want 0", n_consec); end
    endtask

    task automatic test_random();
        settle();
        for (int c = 0; c < 600; c++) begin
            tick();
            n_cmp++; if (bus.en_ram_in !== exp_en) begin n_bad++; $display("FAIL rnd_en@%0d: got %b want %b", c, bus.en_ram_in, exp_en); end
            if (exp_en) begin
                n_cmp++; if (bus.addr_ram_in !== m_addr) begin n_bad++; $display("FAIL rnd_addr@%0d: got %h want %h", c, bus.addr_ram_in, m_addr); end
                n_cmp++; if (bus.we_ram_in !== m_we) begin n_bad++; $display("FAIL rnd_we@%0d: got %b want %b", c, bus.we_ram_in, m_we); end
                if (m_we) begin
                    n_cmp++; if (bus.din_ram_in !== m_wdata) begin n_bad++; $display("FAIL rnd_din@%0d: got %h want %h", c, bus.din_ram_in, m_wdata); end
                end
            end
            n_cmp++; if (bus.if_ack !== exp_if_ack) begin n_bad++; $display("FAIL rnd_if_ack@%0d: got %b want %b", c, bus.if_ack, exp_if_ack); end
            n_cmp++; if (bus.dm_ack !== exp_dm_ack) begin n_bad++; $display("FAIL rnd_dm_ack@%0d: got %b want %b", c, bus.dm_ack, exp_dm_ack); end
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, exp_busy); end
            n_cmp++; if (bus.if_rdata !== m_if_rdata) begin n_bad++; $display("FAIL rnd_if_rdata@%0d: got %h want %h", c, bus.if_rdata, m_if_rdata); end
            n_cmp++; if (bus.dm_rdata !== m_dm_rdata) begin n_bad++; $display("FAIL rnd_dm_rdata@%0d: got %h want %h", c, bus.dm_rdata, m_dm_rdata); end
            // IF requester: hold until ack, then either chain a new request or go quiet
            if (bus.if_req) begin
                if (bus.if_ack) begin
                    if ($urandom_range(1, 0) == 1) bus.if_addr = 8'($urandom_range(15, 0));
                    else bus.if_req = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                bus.if_req = 1'b1; bus.if_addr = 8'($urandom_range(15, 0));
            end
            if (bus.dm_req) begin
                if (bus.dm_ack) begin
                    if ($urandom_range(1, 0) == 1) begin
                        bus.dm_addr = 8'($urandom_range(15, 0)); bus.dm_we = 1'($urandom_range(1, 0));
                        bus.dm_wdata = 16'($urandom);
                    end else bus.dm_req = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                bus.dm_req = 1'b1; bus.dm_addr = 8'($urandom_range(15, 0));
                bus.dm_we = 1'($urandom_range(1, 0)); bus.dm_wdata = 16'($urandom);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            ram[i]     <= 16'((i * 257) ^ 16'h5A5A);
            ref_mem[i] <= 16'((i * 257) ^ 16'h5A5A);
        end
        test_reset();
        test_if_read();
        test_dm_write_read();
        test_contention();
        test_drop_after_accept();
        test_reset_abort();
        test_throughput();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
